psram_req_queue: RTL and testbench
==================================

Name: psram_req_queue

Overview:
- Request-side stage feeding PsramController.
- Accepts byte-granular read/write requests from a traffic source (memory test sequencer, future clients) through a valid/ready handshake and buffers them in a small FIFO.
- Issues them one at a time as single-cycle read/write strobes to the controller, tracks busy, and returns completions with read data, latency and a timeout flag.
- Decouples clients from controller timing and centralises timeout detection.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- TIMEOUT, 31, max cycles from strobe to busy low before the request is declared failed; 8..255.
- LAT_W, 8, width of the per-request latency counter.

Ports:
- clk  in  1  controller clock (same clock as PsramController).
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  queue can accept; equals not-full.
- req_write  in  1  1=byte write, 0=byte read.
- req_addr  in  22  byte address.
- req_wdata  in  8  write byte.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_write  out  1  completed request was a write.
- rsp_err  out  1  completion is a timeout.
- rsp_data  out  8  read byte; 0 for writes and errors.
- rsp_lat  out  LAT_W  cycles from strobe to completion, saturating.
- mem_read  out  1  one-cycle read strobe to controller.
- mem_write  out  1  one-cycle write strobe to controller.
- mem_byte_write  out  1  held at 1.
- mem_addr  out  22  address to controller; stable from strobe until completion.
- mem_din  out  16  {wdata, wdata}.
- mem_dout  in  16  controller read data.
- mem_busy  in  1  controller busy.
- pending  out  log2(DEPTH)+1  FIFO occupancy.
- err_sticky  out  1  set on any timeout; cleared only by reset.

Behaviour:
- Reset (async):
  - FIFO emptied; pending=0; req_ready=1.
  - All rsp_* = 0; mem_read = mem_write = 0; mem_addr = 0; mem_din = 0.
  - err_sticky=0; FSM to IDLE.
- FIFO:
  - Push on req_valid & req_ready. Pop when FSM leaves IDLE to ISSUE.
  - req_ready = (pending != DEPTH), registered-count based.
  - Push and pop in the same cycle: pending unchanged. When full, a same-cycle pop does not raise req_ready that cycle.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, ARM, WAIT, RESP:
  - IDLE: if pending>0 and !mem_busy, pop head into the working register and go to ISSUE. A mem_busy still high after reset mid-operation blocks issue until it drops.
  - ISSUE (1 cycle): assert mem_write or mem_read for exactly one cycle; mem_addr/mem_din driven from the working register; latency counter cleared to 1. Go to ARM.
  - ARM (1 cycle): mem_busy ignored, because the controller raises busy one cycle after the strobe. Go to WAIT.
  - WAIT: latency counter increments each cycle.
    - If !mem_busy: go to RESP.
    - Else if the counter reaches TIMEOUT: go to RESP with the error flag set and err_sticky set.
  - RESP (1 cycle): rsp_valid=1, and rsp_write, rsp_err, rsp_lat are presented.
    - rsp_data = addr[0] ? mem_dout[15:8] : mem_dout[7:0] for a successful read; 0 otherwise.
    - Go to IDLE.
- Minimum request turnaround is 4 cycles (ISSUE, ARM, WAIT, RESP), plus the IDLE cycle.
- rsp_lat saturates at 2^LAT_W-1.
- Outputs not pulsed hold their last value except rsp_valid, mem_read and mem_write, which are 0 outside their state.
- Strictly in-order; one request in flight. No new request is issued after a timeout until mem_busy is low in IDLE.
- Reset mid-request: request discarded, no response, strobes forced low immediately.

Test Plan:
- Single write addr 0x000005 data 0xA7, busy model high for cycles 1..6 after strobe -> mem_write one cycle, mem_din=0xA7A7, rsp_valid with rsp_write=1, rsp_err=0, rsp_lat=7.
- Read addr 0x000005 with mem_dout=0xA7C3 -> rsp_data=0xA7. Addr 0x000004 -> rsp_data=0xC3.
- Push 6 requests back-to-back with DEPTH=4 and busy stuck high -> req_ready low after 4 accepted (the 5th stalls). After busy releases, all 6 complete in order with the correct addresses.
- Busy held high forever -> RESP at rsp_lat=31 with rsp_err=1, rsp_data=0, err_sticky=1. No further strobe until busy drops.
- Push while popping at pending=3 -> pending stays 3. Pointer wrap exercised over 20 requests with no loss or duplication.
- Assert reset during WAIT while busy high -> outputs zeroed, no rsp_valid. The next request is not strobed until mem_busy low.

Source files
------------

// File: rtl/psram_req_queue.sv
// psram_req_queue: buffers byte read/write requests and issues them one at a
// time to PsramController as single-cycle strobes, returning completions.
// Ports:
//   clk, reset             - controller clock, async active-high reset
//   req_valid/ready/write/addr/wdata - client request handshake (ready = not full)
//   rsp_valid/write/err/data/lat     - one-cycle completion pulse plus held fields
//   mem_read/write/byte_write/addr/din/dout/busy - controller strobe interface
//   pending                - FIFO occupancy
//   err_sticky             - set on any timeout, cleared only by reset
module psram_req_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31,
  parameter int LAT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [21:0]              req_addr,
  input  logic [7:0]               req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_write,
  output logic                     rsp_err,
  output logic [7:0]               rsp_data,
  output logic [LAT_W-1:0]         rsp_lat,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     mem_byte_write,
  output logic [21:0]              mem_addr,
  output logic [15:0]              mem_din,
  input  logic [15:0]              mem_dout,
  input  logic                     mem_busy,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     err_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic        write;
    logic [21:0] addr;
    logic [7:0]  wdata;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t state, state_nxt;

  req_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;
  req_t             req_in;
  req_t             wk;          // request currently in flight

  logic [LAT_W-1:0] lat;
  logic [LAT_W-1:0] lat_nxt;
  logic [7:0]       wait_cnt;    // separate from lat so timeout works even if LAT_W is narrow
  logic [8:0]       wait_inc;
  logic             tmo_hit;

  assign req_in    = '{write: req_write, addr: req_addr, wdata: req_wdata};
  // Based on the registered count only, so a pop while full does not
  // reopen the queue in the same cycle.
  assign req_ready = (pending != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;

  assign mem_byte_write = 1'b1;
  assign mem_addr       = wk.addr;
  assign mem_din        = {wk.wdata, wk.wdata};

  assign lat_nxt  = (lat == {LAT_W{1'b1}}) ? lat : lat + LAT_W'(1);
  assign wait_inc = {1'b0, wait_cnt} + 9'd1;
  assign tmo_hit  = mem_busy && (wait_inc >= 9'(TIMEOUT));

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   pending <= pending + CNT_W'(1);
        2'b01:   pending <= pending - CNT_W'(1);
        default: pending <= pending;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pending != '0 && !mem_busy) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_ARM;
      S_ARM:   state_nxt = S_WAIT;   // controller raises busy one cycle after the strobe
      S_WAIT:  if (!mem_busy || tmo_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pop       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE:  pop = (pending != '0) && !mem_busy;
      S_ISSUE: begin
        mem_read  = !wk.write;
        mem_write = wk.write;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Working register, latency tracking and response fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wk         <= '0;
      lat        <= '0;
      wait_cnt   <= '0;
      rsp_write  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      rsp_lat    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (pop) wk <= fifo_mem[rd_ptr];
      if (state == S_ISSUE) begin
        lat      <= LAT_W'(1);
        wait_cnt <= 8'd1;
      end
      if (state == S_WAIT) begin
        lat      <= lat_nxt;
        wait_cnt <= wait_inc[7:0];
        // Response fields are loaded on the way into RESP and then held.
        if (!mem_busy || tmo_hit) begin
          rsp_write <= wk.write;
          rsp_err   <= mem_busy;
          rsp_lat   <= lat_nxt;
          if (!mem_busy && !wk.write)
            rsp_data <= wk.addr[0] ? mem_dout[15:8] : mem_dout[7:0];
          else
            rsp_data <= 8'h00;
          if (mem_busy) err_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_psram_req_queue.sv
module tb_psram_req_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;
  localparam int LAT_W   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [21:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [7:0]  rsp_data;
  logic [LAT_W-1:0] rsp_lat;
  logic        mem_read, mem_write, mem_byte_write;
  logic [21:0] mem_addr;
  logic [15:0] mem_din, mem_dout;
  logic        mem_busy;
  logic [$clog2(DEPTH):0] pending;
  logic        err_sticky;

  always #5 clk = ~clk;

  psram_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .LAT_W(LAT_W)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .rsp_lat(rsp_lat),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_write(mem_byte_write),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy),
    .pending(pending), .err_sticky(err_sticky)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Controller busy model: after each strobe, busy is high for cycles 1..L.
  int   len_q[$];
  int   busy_cnt = 0;
  logic busy_stuck = 1'b0;
  assign mem_busy = busy_stuck | (busy_cnt != 0);

  always @(posedge clk) begin
    if (mem_read || mem_write) begin
      if (len_q.size() > 0) busy_cnt <= len_q.pop_front();
      else                  busy_cnt <= 0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  typedef struct { bit w; bit [21:0] a; bit [7:0] d; } strb_t;
  typedef struct { bit w; bit e; int lat; bit [7:0] dat; } rsp_t;
  strb_t exp_strobe_q[$];
  rsp_t  exp_rsp_q[$];
  int    strobe_cnt = 0;
  int    rsp_cnt = 0;
  bit    prev_strobe = 0;

  // Monitor: strobes and completions are checked in order against expectations.
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      strobe_cnt++;
      chk("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
      chk("strobe_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      if (exp_strobe_q.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        strb_t s;
        s = exp_strobe_q.pop_front();
        chk("strobe_write", {31'd0, mem_write}, {31'd0, s.w});
        chk("strobe_addr", {10'd0, mem_addr}, {10'd0, s.a});
        chk("strobe_din", {16'd0, mem_din}, {16'd0, s.d, s.d});
      end
    end
    prev_strobe = mem_read || mem_write;
    if (rsp_valid) begin
      rsp_cnt++;
      if (exp_rsp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t r;
        r = exp_rsp_q.pop_front();
        chk("rsp_write", {31'd0, rsp_write}, {31'd0, r.w});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.e});
        chk("rsp_lat", {24'd0, rsp_lat}, r.lat);
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, r.dat});
      end
    end
  end

  // Reference: busy window ends after cycle L; completion happens on the
  // first cycle >= 2 after the strobe where busy is low, unless busy is
  // still high at cycle TIMEOUT.
  function automatic void model(input bit w, input bit [21:0] a, input bit [15:0] dout,
                                input int L, output bit e, output int lat, output bit [7:0] dat);
    if (L >= TIMEOUT) begin
      e = 1; lat = TIMEOUT; dat = 8'h00;
    end else begin
      e = 0;
      lat = (L < 2) ? 2 : L + 1;
      dat = w ? 8'h00 : (a[0] ? dout[15:8] : dout[7:0]);
    end
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic send(input bit w, input bit [21:0] a, input bit [7:0] d, input int L,
                      input bit e, input int lat, input bit [7:0] dat);
    int waited = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("send_ready", {31'd0, req_ready}, 32'd1);
    if (req_ready) begin
      exp_strobe_q.push_back('{w: w, a: a, d: d});
      exp_rsp_q.push_back('{w: w, e: e, lat: lat, dat: dat});
      len_q.push_back(L);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_rsp_q.size() != 0 || pending != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_rsp_q.size(), 32'd0);
    n = 0;
    while (mem_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    bit w; bit [21:0] a; bit [7:0] d; int L; bit [15:0] dout;
    bit e_err; int e_lat; bit [7:0] e_data;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, n;
    bit e; int lat; bit [7:0] dat;
    bit [15:0] rnd_dout;

    tbl[0] = '{1, 22'h000005, 8'hA7, 6,  16'h0000, 0, 7,  8'h00};
    tbl[1] = '{0, 22'h000005, 8'h00, 6,  16'hA7C3, 0, 7,  8'hA7};
    tbl[2] = '{0, 22'h000004, 8'h00, 6,  16'hA7C3, 0, 7,  8'hC3};
    tbl[3] = '{0, 22'h000003, 8'h00, 0,  16'h1234, 0, 2,  8'h12};
    tbl[4] = '{1, 22'h3FFFFF, 8'h5A, 30, 16'hFFFF, 0, 31, 8'h00};
    tbl[5] = '{0, 22'h000002, 8'h00, 40, 16'hFFFF, 1, 31, 8'h00};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_dout = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_pending", {29'd0, pending}, 32'd0);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_lat", {24'd0, rsp_lat}, 32'd0);
    chk("reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("reset_mem_addr", {10'd0, mem_addr}, 32'd0);
    chk("reset_mem_din", {16'd0, mem_din}, 32'd0);
    chk("reset_err_sticky", {31'd0, err_sticky}, 32'd0);
    chk("byte_write_high", {31'd0, mem_byte_write}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Timeout: busy goes high after the strobe and never drops.
    s0 = strobe_cnt;
    send(0, 22'h000011, 8'h00, 0, 1, TIMEOUT, 8'h00);
    n = 0;
    while (strobe_cnt == s0 && n < 50) begin @(negedge clk); n++; end
    busy_stuck = 1'b1;
    n = 0;
    while (exp_rsp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("timeout_rsp_seen", exp_rsp_q.size(), 32'd0);
    chk("timeout_err_sticky", {31'd0, err_sticky}, 32'd1);
    send(1, 22'h000012, 8'h3C, 3, 0, 4, 8'h00);
    s0 = strobe_cnt;
    repeat (30) @(negedge clk);
    chk("no_strobe_while_busy", strobe_cnt, s0);
    chk("held_pending", {29'd0, pending}, 32'd1);
    busy_stuck = 1'b0;
    wait_idle(300);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      mem_dout = tbl[i].dout;
      send(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].L, tbl[i].e_err, tbl[i].e_lat, tbl[i].e_data);
      wait_idle(300);
    end

    // Backpressure: 4 accepted while busy blocks issue, 5th stalls.
    mem_dout = 16'h5AA5;
    busy_stuck = 1'b1;
    for (int i = 0; i < 4; i++)
      send(1, 22'(32'h100 + i), 8'(i), 1, 0, 2, 8'h00);
    chk("full_pending", {29'd0, pending}, 32'd4);
    chk("full_not_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 22'h104; req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("stall_not_ready", {31'd0, req_ready}, 32'd0);
    chk("stall_pending", {29'd0, pending}, 32'd4);
    busy_stuck = 1'b0;
    send(0, 22'h000104, 8'h00, 2, 0, 3, 8'hA5);
    send(0, 22'h000105, 8'h00, 2, 0, 3, 8'h5A);
    wait_idle(400);

    // Push and pop in the same cycle at pending=3.
    busy_stuck = 1'b1;
    for (int i = 0; i < 3; i++)
      send(1, 22'(32'h200 + i), 8'(8'h10 + i), 0, 0, 2, 8'h00);
    chk("pp_pending_before", {29'd0, pending}, 32'd3);
    busy_stuck = 1'b0;
    send(1, 22'h000203, 8'h13, 0, 0, 2, 8'h00);
    chk("pp_pending_after", {29'd0, pending}, 32'd3);
    wait_idle(400);

    // Randomized traffic, also exercises pointer wrap.
    rnd_dout = 16'($urandom);
    mem_dout = rnd_dout;
    for (int i = 0; i < 30; i++) begin
      bit w; bit [21:0] a; bit [7:0] d; int L;
      w = 1'($urandom);
      a = 22'($urandom);
      d = 8'($urandom);
      L = ($urandom_range(0, 9) == 0) ? 35 : $urandom_range(0, 8);
      model(w, a, rnd_dout, L, e, lat, dat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(w, a, d, L, e, lat, dat);
    end
    wait_idle(3000);

    // Reset while waiting on busy.
    s0 = strobe_cnt;
    send(0, 22'h000333, 8'h00, 60, 1, TIMEOUT, 8'h00);
    n = 0;
    while (strobe_cnt == s0 && n < 50) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("mid_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_reset_mem_addr", {10'd0, mem_addr}, 32'd0);
    chk("mid_reset_mem_din", {16'd0, mem_din}, 32'd0);
    chk("mid_reset_pending", {29'd0, pending}, 32'd0);
    chk("mid_reset_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_reset_err_sticky", {31'd0, err_sticky}, 32'd0);
    exp_rsp_q.delete();
    exp_strobe_q.delete();
    len_q.delete();
    r0 = rsp_cnt;
    @(negedge clk);
    rst = 1'b0;
    chk("busy_after_reset", {31'd0, mem_busy}, 32'd1);
    mem_dout = 16'hBEEF;
    s0 = strobe_cnt;
    send(0, 22'h000001, 8'h00, 2, 0, 3, 8'hBE);
    n = 0;
    while (mem_busy && n < 100) begin @(negedge clk); n++; end
    chk("no_strobe_until_busy_low", strobe_cnt, s0);
    chk("no_rsp_for_discarded", rsp_cnt, r0);
    wait_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
